// File: rtl/line_buffer_3x3.sv
// Line buffer feeding the 3x3 window stage: two circular line memories give
// rows y-2, y-1 alongside the current pixel. Optional top zero padding: LB_ZERO_PAD_EN.
module line_buffer_3x3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned HEIGHT     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      pix_in,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      pix_curr,
  output logic [DATA_WIDTH-1:0]      pix_m1,
  output logic [DATA_WIDTH-1:0]      pix_m2,
  output logic [$clog2(WIDTH)-1:0]   out_col,
  output logic [$clog2(HEIGHT)-1:0]  out_row,
  output logic                       frame_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  ov_q, ov_d;
  logic                  fd_q, fd_d;
  logic [DATA_WIDTH-1:0] curr_q, m1_q, m2_q;
  logic [DATA_WIDTH-1:0] m1_d, m2_d;
  logic [CW-1:0]         ocol_q;
  logic [RW-1:0]         orow_q;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  // lineA holds row y-1, lineB holds row y-2; contents are never reset.
  logic [DATA_WIDTH-1:0] line_a_q [WIDTH];
  logic [DATA_WIDTH-1:0] line_b_q [WIDTH];

  always_comb begin
    rd_a = line_a_q[col_q];
    rd_b = line_b_q[col_q];
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
`ifdef LB_ZERO_PAD_EN
    ov_d = in_valid;
    m2_d = (row_q < RW'(2)) ? '0 : rd_b;
    m1_d = (row_q == '0)    ? '0 : rd_a;
`else
    ov_d = in_valid && (row_q >= RW'(2));
    m2_d = rd_b;
    m1_d = rd_a;
`endif
    fd_d = ov_d && (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
  end

  // Read-before-write: the comb reads above see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_b_q[col_q] <= line_a_q[col_q];
      line_a_q[col_q] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      ov_q   <= 1'b0;
      fd_q   <= 1'b0;
      curr_q <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      ocol_q <= '0;
      orow_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ov_q  <= ov_d;
      fd_q  <= fd_d;
      if (in_valid) begin
        curr_q <= pix_in;
        m1_q   <= m1_d;
        m2_q   <= m2_d;
        ocol_q <= col_q;
        orow_q <= row_q;
      end
    end
  end

  assign out_valid  = ov_q;
  assign frame_done = fd_q;
  assign pix_curr   = curr_q;
  assign pix_m1     = m1_q;
  assign pix_m2     = m2_q;
  assign out_col    = ocol_q;
  assign out_row    = orow_q;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench for line_buffer_3x3: stimulus pushes expected triples, a
// negedge monitor pops and compares them. Honours LB_ZERO_PAD_EN.
module tb_line_buffer_3x3;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 10;
  localparam int unsigned H  = 8;
`ifdef LB_ZERO_PAD_EN
  localparam int unsigned FIRST_ROW = 0;
  localparam int unsigned N_VALID   = H * W;
`else
  localparam int unsigned FIRST_ROW = 2;
  localparam int unsigned N_VALID   = (H - 2) * W;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  in_valid = 1'b0;
  logic [DW-1:0]         pix_in = '0;
  logic                  out_valid;
  logic [DW-1:0]         pix_curr, pix_m1, pix_m2;
  logic [$clog2(W)-1:0]  out_col;
  logic [$clog2(H)-1:0]  out_row;
  logic                  frame_done;

  line_buffer_3x3 #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .pix_in     (pix_in),
    .out_valid  (out_valid),
    .pix_curr   (pix_curr),
    .pix_m1     (pix_m1),
    .pix_m2     (pix_m2),
    .out_col    (out_col),
    .out_row    (out_row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned m2;
    int unsigned m1;
    int unsigned curr;
    int unsigned col;
    int unsigned row;
    bit          fd;
  } exp_t;

  exp_t q[$];
  exp_t last_e, first_v, last_v;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid = 0;
  int   n_fd    = 0;
  bit   exp_ov = 1'b0, eov_s = 1'b0, iv_s = 1'b0, last_live = 1'b0;

  function automatic int unsigned pix(input int unsigned off, input int unsigned r,
                                      input int unsigned c);
    return off + r * 16 + c + 1;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    iv_s  <= in_valid && rst_n;
    eov_s <= exp_ov && rst_n;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      last_live = 1'b0;
    end else begin
      check("out_valid", out_valid, eov_s);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: unexpected output, got m2=%0d m1=%0d curr=%0d, expected none",
                   pix_m2, pix_m1, pix_curr);
        end else begin
          e = q.pop_front();
          check("pix_m2", pix_m2, e.m2);
          check("pix_m1", pix_m1, e.m1);
          check("pix_curr", pix_curr, e.curr);
          check("out_col", out_col, e.col);
          check("out_row", out_row, e.row);
          check("frame_done", frame_done, e.fd);
          last_e    = e;
          last_live = 1'b1;
          n_valid++;
          if (frame_done) n_fd++;
          last_v = '{m2: pix_m2, m1: pix_m1, curr: pix_curr, col: out_col, row: out_row,
                     fd: frame_done};
          if (e.row == FIRST_ROW && e.col == 0) first_v = last_v;
        end
      end else begin
        check("frame_done_idle", frame_done, 0);
        if (!iv_s && last_live) begin
          check("hold_m2", pix_m2, last_e.m2);
          check("hold_m1", pix_m1, last_e.m1);
          check("hold_curr", pix_curr, last_e.curr);
        end
        if (iv_s) last_live = 1'b0;
      end
    end
  end

  task automatic send(input int unsigned off, input int unsigned r, input int unsigned c);
    exp_t e;
    bit   v;
`ifdef LB_ZERO_PAD_EN
    v    = 1'b1;
    e.m2 = (r < 2)  ? 0 : pix(off, r - 2, c);
    e.m1 = (r == 0) ? 0 : pix(off, r - 1, c);
`else
    v    = (r >= 2);
    e.m2 = v ? pix(off, r - 2, c) : 0;
    e.m1 = v ? pix(off, r - 1, c) : 0;
`endif
    e.curr = pix(off, r, c);
    e.col  = c;
    e.row  = r;
    e.fd   = (r == H - 1) && (c == W - 1);
    in_valid = 1'b1;
    pix_in   = DW'(pix(off, r, c));
    exp_ov   = v;
    if (v) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    pix_in   = 8'hA5;
    exp_ov   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    exp_ov   = 1'b0;
  endtask

  task automatic frame(input int unsigned off, input bit alt,
                       input int unsigned stop_r, input int unsigned stop_c);
    for (int unsigned r = 0; r < H; r++) begin
      for (int unsigned c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        send(off, r, c);
        if (alt) gap();
      end
    end
  endtask

  task automatic check_frame_stats(input string tag, input int unsigned fds,
                                   input int unsigned m2, input int unsigned m1,
                                   input int unsigned cu);
    @(negedge clk);
    #1;
    check({tag, "_valid_count"}, n_valid, N_VALID * fds);
    check({tag, "_frame_done_count"}, n_fd, fds);
    check({tag, "_first_m2"}, first_v.m2, m2);
    check({tag, "_first_m1"}, first_v.m1, m1);
    check({tag, "_first_curr"}, first_v.curr, cu);
    check({tag, "_first_row"}, first_v.row, FIRST_ROW);
    check({tag, "_first_col"}, first_v.col, 0);
    n_valid = 0;
    n_fd    = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pix_curr"}, pix_curr, 0);
    check({tag, "_pix_m1"}, pix_m1, 0);
    check({tag, "_pix_m2"}, pix_m2, 0);
    check({tag, "_out_col"}, out_col, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous frame.
    frame(0, 1'b0, H, 0);
    idle();
`ifdef LB_ZERO_PAD_EN
    check_frame_stats("cont", 1, 0, 0, 1);
`else
    check_frame_stats("cont", 1, 1, 17, 33);
`endif
    check("cont_last_m2", last_v.m2, 90);
    check("cont_last_m1", last_v.m1, 106);
    check("cont_last_curr", last_v.curr, 122);

    // Same frame with a gap after every pixel.
    frame(0, 1'b1, H, 0);
    idle();
`ifdef LB_ZERO_PAD_EN
    check_frame_stats("alt", 1, 0, 0, 1);
`else
    check_frame_stats("alt", 1, 1, 17, 33);
`endif

    // Two frames with no idle between them.
    frame(0, 1'b0, H, 0);
    frame(128, 1'b0, H, 0);
    idle();
`ifdef LB_ZERO_PAD_EN
    check_frame_stats("b2b", 2, 0, 0, 129);
`else
    check_frame_stats("b2b", 2, 129, 145, 161);
`endif

    // Abandon a frame at (4,3) with an asynchronous reset between edges.
    frame(0, 1'b0, 4, 3);
    idle();
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    q.delete();
    n_valid = 0;
    n_fd    = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(0, 1'b0, H, 0);
    idle();
`ifdef LB_ZERO_PAD_EN
    check_frame_stats("post_reset", 1, 0, 0, 1);
`else
    check_frame_stats("post_reset", 1, 1, 17, 33);
`endif

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_3x3.md
Name: line_buffer_3x3

Overview:
- Upstream neighbour of the 3x3 window stage.
- Accepts a raster-order pixel stream, one pixel per accepted cycle.
- Stores the two previous image lines in circular line memories.
- Emits three vertically aligned pixels per column: pix_m2 (row y-2), pix_m1 (row y-1), pix_curr (row y), with out_valid driving the window stage's in_valid.

Parameters:
- DATA_WIDTH, 8, pixel bit width.
- WIDTH, 10, pixels per line; must be >= 2.
- HEIGHT, 8, lines per frame; must be >= 3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pix_in is valid this cycle; no backpressure.
- pix_in  input  DATA_WIDTH  incoming pixel, raster order.
- out_valid  output  1  the pix_m2/pix_m1/pix_curr triple is valid.
- pix_curr  output  DATA_WIDTH  pixel (y, x).
- pix_m1  output  DATA_WIDTH  pixel (y-1, x).
- pix_m2  output  DATA_WIDTH  pixel (y-2, x).
- out_col  output  $clog2(WIDTH)  column x of the current output.
- out_row  output  $clog2(HEIGHT)  row y of the current output.
- frame_done  output  1  one-cycle pulse aligned with the output for the last pixel of a frame.

Behaviour:
- Reset: all outputs, col/row counters and the output registers go to 0 asynchronously. Line memory contents are not reset; they are don't-care and are masked by out_valid.
- Internal state:
  - col counter 0..WIDTH-1 and row counter 0..HEIGHT-1, both advancing only on in_valid.
  - col wraps WIDTH-1 -> 0 and increments row.
  - row wraps HEIGHT-1 -> 0 (next frame) with no idle cycle required.
- Line memories: lineA holds row y-1, lineB holds row y-2, each WIDTH deep and addressed by col.
  - On an accepted pixel: read lineA[col] and lineB[col], then write lineB[col] <= old lineA[col] and lineA[col] <= pix_in in the same cycle.
  - The read returns the old value (read-before-write).
- Latency: exactly 1 cycle. The pixel accepted at edge N appears on the outputs after edge N, together with the stored rows for the same column.
- out_valid:
  - Registered; equals the in_valid of the previous cycle AND (row >= 2) at acceptance.
  - Rows 0 and 1 prime the memories only.
  - Yields (HEIGHT-2)*WIDTH valid outputs per frame.
- Gaps (in_valid=0): counters and memories are held; out_valid=0 next cycle; the data outputs hold their last values.
- frame_done = out_valid AND out_row==HEIGHT-1 AND out_col==WIDTH-1.
- Back-to-back frames: the first two rows of the new frame are again priming. The stale previous-frame rows are overwritten before they are used.
- Reset mid-frame: the frame is abandoned. The next accepted pixel is treated as (0,0).
- Arithmetic: counters are unsigned, compared against WIDTH-1 and HEIGHT-1; no saturation.

Optional Feature:
- Macro LB_ZERO_PAD_EN.
- When defined:
  - out_valid is asserted for every accepted pixel, including rows 0 and 1.
  - pix_m2 is forced to 0 when out_row<2.
  - pix_m1 is forced to 0 when out_row==0.
  - This yields HEIGHT*WIDTH outputs per frame (top zero padding).
- When undefined: priming behaviour as above, with no forced zeros.

Test Plan:
- Continuous frame, WIDTH=10, HEIGHT=8, pix_in=row*16+col+1:
  - no out_valid during the first 20 accepted pixels;
  - first valid output is m2=1, m1=17, curr=33, out_row=2, out_col=0;
  - last valid output is m2=90, m1=106, curr=122;
  - exactly 60 out_valid pulses and 1 frame_done.
- Same frame with in_valid alternating 1/0:
  - identical valid output sequence;
  - out_valid=0 in the cycle after each gap;
  - outputs held during gaps.
- Two frames back-to-back (second frame uses +128 offset):
  - frame_done pulses twice;
  - second frame's first valid output is m2=129, m1=145, curr=161, never mixed with frame-1 data.
- rst_n asserted mid-cycle at row 4, col 3:
  - outputs go to 0 immediately, without waiting for a clock edge;
  - after release, the next frame again requires 20 priming pixels before out_valid.
- Compiled with LB_ZERO_PAD_EN:
  - first output is m2=0, m1=0, curr=1;
  - row-1 col-0 output is m2=0, m1=1, curr=17;
  - 80 valid outputs per frame.
